// File: rtl/ahb_frame_sequencer_pkg.sv
// Shared types and helpers for the frame sequencer: FSM state encoding and word addressing.
package ahb_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        ISS_RD  = 3'd2,
        WAIT_RD = 3'd3,
        ISS_WR  = 3'd4,
        WAIT_WR = 3'd5,
        FIN     = 3'd6
    } seq_state_t;

    localparam int WORD_BYTES = 4;

    // Byte address of word idx in a frame; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + idx * 32'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/ahb_frame_sequencer_if.sv
// Bus-side signals of the frame sequencer: AHB master request/complete plus pixel and result streams.
interface ahb_frame_sequencer_if;

    logic        re;
    logic        we;
    logic [31:0] mcu_raddr;
    logic [31:0] mcu_waddr;
    logic [31:0] buffer2_data;
    logic        read_complete;
    logic        write_complete;
    logic [31:0] greyscale_data;

    // pix_* and res_* are valid/ready streams: a word moves on a rising clk edge where
    // valid & ready are both high; valid never waits on ready, and data is stable while valid is high.
    logic        pix_valid;
    logic [31:0] pix_data;
    logic        pix_ready;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;

    modport master (
        output re, we, mcu_raddr, mcu_waddr, buffer2_data, pix_valid, pix_data, res_ready,
        input  read_complete, write_complete, greyscale_data, pix_ready, res_valid, res_data
    );

    modport slave (
        input  re, we, mcu_raddr, mcu_waddr, buffer2_data, pix_valid, pix_data, res_ready,
        output read_complete, write_complete, greyscale_data, pix_ready, res_valid, res_data
    );

endinterface

// File: rtl/ahb_frame_sequencer_hold_slot.sv
// One-entry valid/ready holding register; accepts only when empty.
module ahb_frame_sequencer_hold_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             full;
    logic [WIDTH-1:0] data;
    logic             fill;

    assign in_ready  = ~full;
    assign out_valid = full;
    assign out_data  = data;
    assign fill      = in_valid & ~full;

    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            if (fill) begin
                data <= in_data;
            end
            full <= fill | (full & ~out_ready);
        end
    end

endmodule

// File: rtl/ahb_frame_sequencer.sv
// Walks a source frame and a destination frame with one outstanding AHB transaction at a time,
// streaming read words to the edge pipeline and writing its result words back.
module ahb_frame_sequencer
    import ahb_frame_sequencer_pkg::*;
#(
    parameter logic [31:0] SRC_BASE = 32'h0000_0000,
    parameter logic [31:0] DST_BASE = 32'h0001_0000,
    parameter int          NUM_RD   = 16,
    parameter int          NUM_WR   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    ahb_frame_sequencer_if.master bus,
    output logic                  busy,
    output logic                  done,
    output seq_state_t            state_dbg
);

    localparam int MAX_N = (NUM_RD > NUM_WR) ? NUM_RD : NUM_WR;
    localparam int CW    = $clog2(MAX_N + 1);
    localparam logic [CW-1:0] NRD = CW'(NUM_RD);
    localparam logic [CW-1:0] NWR = CW'(NUM_WR);

    seq_state_t    state, state_nxt;
    logic [CW-1:0] rd_cnt, wr_cnt;
    logic          pix_empty, pix_full;
    logic          res_empty, res_full;
    logic [31:0]   res_word;
    logic          rd_fill, wr_done, res_room;

    assign rd_fill   = (state == WAIT_RD) & bus.read_complete;
    assign wr_done   = (state == WAIT_WR) & bus.write_complete;
    // The slot count is zero whenever the slot is empty, so the room test reduces to wr_cnt.
    assign res_room  = busy & res_empty & (wr_cnt < NWR);
    assign bus.res_ready = res_room;
    assign bus.pix_valid = pix_full;
    assign state_dbg = state;

    ahb_frame_sequencer_hold_slot #(.WIDTH(32)) u_pix_slot (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_fill),
        .in_ready  (pix_empty),
        .in_data   (bus.greyscale_data),
        .out_valid (pix_full),
        .out_data  (bus.pix_data),
        .out_ready (bus.pix_ready)
    );

    ahb_frame_sequencer_hold_slot #(.WIDTH(32)) u_res_slot (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.res_valid & res_room),
        .in_ready  (res_empty),
        .in_data   (bus.res_data),
        .out_valid (res_full),
        .out_data  (res_word),
        .out_ready (wr_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARB;
            ARB: begin
                if (res_full && (wr_cnt < NWR))            state_nxt = ISS_WR;
                else if ((rd_cnt < NRD) && pix_empty)      state_nxt = ISS_RD;
                else if ((rd_cnt == NRD) && (wr_cnt == NWR)) state_nxt = FIN;
            end
            ISS_RD:  state_nxt = WAIT_RD;
            WAIT_RD: if (bus.read_complete) state_nxt = ARB;
            ISS_WR:  state_nxt = WAIT_WR;
            WAIT_WR: if (bus.write_complete) state_nxt = ARB;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request strobes and addresses are registered off state_nxt so they line up with ISS_* states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            rd_cnt           <= '0;
            wr_cnt           <= '0;
            bus.re           <= 1'b0;
            bus.we           <= 1'b0;
            bus.mcu_raddr    <= '0;
            bus.mcu_waddr    <= '0;
            bus.buffer2_data <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && start) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end
            if (rd_fill) rd_cnt <= rd_cnt + 1'b1;
            if (wr_done) wr_cnt <= wr_cnt + 1'b1;
            bus.re <= (state_nxt == ISS_RD);
            bus.we <= (state_nxt == ISS_WR);
            if (state_nxt == ISS_RD) begin
                bus.mcu_raddr <= word_addr(SRC_BASE, 32'(rd_cnt));
            end
            if (state_nxt == ISS_WR) begin
                bus.mcu_waddr    <= word_addr(DST_BASE, 32'(wr_cnt));
                bus.buffer2_data <= res_word;
            end
            busy <= (state_nxt != IDLE) && (state_nxt != FIN);
            done <= (state_nxt == FIN);
        end
    end

endmodule

// File: tb/tb_ahb_frame_sequencer.sv
// Directed bench for ahb_frame_sequencer with a 2-cycle AHB responder and a queue scoreboard.
module tb_ahb_frame_sequencer;
    import ahb_frame_sequencer_pkg::*;

    localparam logic [31:0] SRC = 32'h0000_0000;
    localparam logic [31:0] DST = 32'h0001_0000;
    localparam int          N   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done;
    seq_state_t state_dbg;

    logic rc_model = 1'b0, rc_inj = 1'b0;
    logic wc_model = 1'b0, wc_inj = 1'b0;

    ahb_frame_sequencer_if bus ();
    assign bus.read_complete  = rc_model | rc_inj;
    assign bus.write_complete = wc_model | wc_inj;

    ahb_frame_sequencer #(
        .SRC_BASE (SRC),
        .DST_BASE (DST),
        .NUM_RD   (N),
        .NUM_WR   (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int re_cnt = 0, we_cnt = 0, pix_cnt = 0, done_cnt = 0;
    int wr_push = 0;
    logic [31:0] exp_raddr_q[$];
    logic [31:0] exp_pix_q[$];
    logic [31:0] exp_waddr_q[$];
    logic [31:0] exp_wdata_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pix_word(input logic [31:0] addr);
        return 32'h5A00_0000 ^ (addr * 32'd3 + 32'h11);
    endfunction

    // AHB responder: completion two cycles after each request.
    initial begin : ahb_model
        logic [31:0] rd_addr;
        forever begin
            @(negedge clk);
            if (bus.re === 1'b1) begin
                rd_addr = bus.mcu_raddr;
                repeat (2) @(negedge clk);
                bus.greyscale_data = pix_word(rd_addr);
                exp_pix_q.push_back(pix_word(rd_addr));
                rc_model = 1'b1;
                @(negedge clk);
                rc_model = 1'b0;
                bus.greyscale_data = '0;
            end else if (bus.we === 1'b1) begin
                repeat (2) @(negedge clk);
                wc_model = 1'b1;
                @(negedge clk);
                wc_model = 1'b0;
            end
        end
    end

    // Output monitor: pops expected requests/pixels as the DUT produces them.
    initial begin : monitor
        logic [31:0] b2_hold;
        logic        wr_out;
        b2_hold = '0;
        wr_out  = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (bus.re === 1'b1) begin
                re_cnt++;
                check("re_we_excl", 32'(bus.we), 32'd0);
                if (exp_raddr_q.size() == 0) check("re_unexpected", 32'(bus.re), 32'd0);
                else check("raddr", bus.mcu_raddr, exp_raddr_q.pop_front());
            end
            if (bus.we === 1'b1) begin
                we_cnt++;
                if (exp_waddr_q.size() == 0) check("we_unexpected", 32'(bus.we), 32'd0);
                else begin
                    check("waddr", bus.mcu_waddr, exp_waddr_q.pop_front());
                    check("wdata", bus.buffer2_data, exp_wdata_q.pop_front());
                end
                b2_hold = bus.buffer2_data;
                wr_out  = 1'b1;
            end
            if (wr_out && bus.write_complete === 1'b1) begin
                check("b2_held", bus.buffer2_data, b2_hold);
                wr_out = 1'b0;
            end
            if (bus.pix_valid === 1'b1 && bus.pix_ready === 1'b1) begin
                pix_cnt++;
                if (exp_pix_q.size() == 0) check("pix_unexpected", 32'(bus.pix_valid), 32'd0);
                else check("pix_data", bus.pix_data, exp_pix_q.pop_front());
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic push_reads();
        for (int i = 0; i < N; i++) exp_raddr_q.push_back(SRC + 32'(i * 4));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_result(input logic [31:0] d);
        bus.res_valid = 1'b1;
        bus.res_data  = d;
        for (int i = 0; i < 200; i++) begin
            if (bus.res_ready === 1'b1) break;
            @(negedge clk);
        end
        check("res_accept", 32'(bus.res_ready), 32'd1);
        if (bus.res_ready === 1'b1) begin
            exp_waddr_q.push_back(DST + 32'(wr_push * 4));
            exp_wdata_q.push_back(d);
            wr_push++;
        end
        @(negedge clk);
        bus.res_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_re"}, 32'(bus.re), 32'd0);
        check({tag, "_we"}, 32'(bus.we), 32'd0);
        check({tag, "_raddr"}, bus.mcu_raddr, 32'd0);
        check({tag, "_waddr"}, bus.mcu_waddr, 32'd0);
        check({tag, "_b2"}, bus.buffer2_data, 32'd0);
        check({tag, "_pix_valid"}, 32'(bus.pix_valid), 32'd0);
        check({tag, "_pix_data"}, bus.pix_data, 32'd0);
        check({tag, "_res_ready"}, 32'(bus.res_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int first_we, first_re;
        int re0, we0, pix0, done0;
        logic seen;

        rst = 1'b1;
        start = 1'b0;
        bus.pix_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data = '0;
        bus.greyscale_data = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Frame 1: four reads streamed downstream, then four result writes.
        bus.pix_ready = 1'b1;
        push_reads();
        pulse_start();
        check("lat_re_early", 32'(bus.re), 32'd0);
        check("busy_set", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_re_2cyc", 32'(bus.re), 32'd1);
        check("first_raddr", bus.mcu_raddr, SRC);
        for (int i = 0; i < 200 && pix_cnt < N; i++) @(negedge clk);
        check("f1_pix_beats", 32'(pix_cnt), 32'(N));
        repeat (10) @(negedge clk);
        check("f1_reads", 32'(re_cnt), 32'(N));
        check("f1_no_done", 32'(done_cnt), 32'd0);
        check("f1_still_busy", 32'(busy), 32'd1);
        check("f1_state_arb", 32'(state_dbg), 32'(ARB));

        wr_push = 0;
        for (int k = 0; k < N; k++) send_result(32'hA0 + 32'(k));
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("f1_done", 32'(seen), 32'd1);
        check("f1_busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        check("f1_done_1cyc", 32'(done), 32'd0);
        check("f1_idle", 32'(state_dbg), 32'(IDLE));
        check("f1_writes", 32'(we_cnt), 32'(N));
        check("f1_q_empty", 32'(exp_raddr_q.size() + exp_pix_q.size() + exp_waddr_q.size()), 32'd0);

        // Frame 2: stalled pixel slot, then write priority over a pending read.
        wr_push = 0;
        bus.pix_ready = 1'b0;
        push_reads();
        re0 = re_cnt;
        we0 = we_cnt;
        pulse_start();
        repeat (30) @(negedge clk);
        check("stall_one_read", 32'(re_cnt - re0), 32'd1);
        check("stall_pix_valid", 32'(bus.pix_valid), 32'd1);
        bus.pix_ready = 1'b1;
        bus.res_valid = 1'b1;
        bus.res_data  = 32'hA0;
        check("prio_res_ready", 32'(bus.res_ready), 32'd1);
        exp_waddr_q.push_back(DST);
        exp_wdata_q.push_back(32'hA0);
        wr_push = 1;
        first_we = -1;
        first_re = -1;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (t == 1) bus.res_valid = 1'b0;
            if (bus.we === 1'b1 && first_we < 0) first_we = t;
            if (bus.re === 1'b1 && first_re < 0) first_re = t;
        end
        check("prio_we_cycle", 32'(first_we), 32'd2);
        check("prio_we_before_re", 32'(first_we > 0 && first_re > first_we), 32'd1);
        check("re_gap_min2", 32'(first_re >= 2), 32'd1);
        for (int k = 1; k < N; k++) send_result(32'hA0 + 32'(k));
        bus.res_valid = 1'b1;
        bus.res_data  = 32'hA4;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.res_ready === 1'b1) seen = 1'b1;
        end
        check("fifth_refused", 32'(seen), 32'd0);
        bus.res_valid = 1'b0;
        for (int i = 0; i < 200 && done_cnt < 2; i++) @(negedge clk);
        @(negedge clk);
        check("f2_done", 32'(done_cnt), 32'd2);
        check("f2_busy_clear", 32'(busy), 32'd0);
        check("f2_writes", 32'(we_cnt - we0), 32'(N));
        check("f2_reads", 32'(re_cnt - re0), 32'(N));
        check("f2_q_empty", 32'(exp_raddr_q.size() + exp_pix_q.size() + exp_waddr_q.size()), 32'd0);

        // Frame 3: start and stray write_complete while busy, then reset during WAIT_RD.
        wr_push = 0;
        push_reads();
        we0 = we_cnt;
        done0 = done_cnt;
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.re === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("f3_first_re", 32'(seen), 32'd1);
        @(negedge clk);
        check("f3_wait_rd", 32'(state_dbg), 32'(WAIT_RD));
        start  = 1'b1;
        wc_inj = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wc_inj = 1'b0;
        @(negedge clk);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.re === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("f3_second_re", 32'(seen), 32'd1);
        check("start_busy_ignored", bus.mcu_raddr, SRC + 32'd4);
        check("stray_wc_no_write", 32'(we_cnt - we0), 32'd0);
        check("f3_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("f3_wait_rd2", 32'(state_dbg), 32'(WAIT_RD));
        pix0 = pix_cnt;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rc_inj = 1'b1;
        bus.greyscale_data = 32'hDEAD_BEEF;
        @(negedge clk);
        rc_inj = 1'b0;
        bus.greyscale_data = '0;
        repeat (10) @(negedge clk);
        check_all_zero("post_rst");
        check("rst_no_pix", 32'(pix_cnt - pix0), 32'd0);
        check("rst_no_done", 32'(done_cnt - done0), 32'd0);
        exp_raddr_q.delete();
        exp_pix_q.delete();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
